// File: rtl/crf_pkg.sv
// Shared definitions for the config register file and its AXI4-Lite initiator.
package crf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } lite_mst_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [31:0] UPSTR  = 32'h0000_0000;
  localparam logic [31:0] UPENDR = 32'h0000_0004;

endpackage

// File: rtl/crf_lite_master.sv
// AXI4-Lite initiator: one register command in, one AXI transaction out, one response back.
// Every output is a flop; the next-state block computes next values for all of them.
module crf_lite_master
  import crf_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_write,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  input  logic [1:0]                  m_axi_bresp,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  output logic                        busy,
  output logic [7:0]                  err_cnt
);

  lite_mst_state_e r_state, w_state_nxt;

  logic r_cmd_ready, w_cmd_ready_nxt;
  logic r_awvalid, w_awvalid_nxt;
  logic r_wvalid, w_wvalid_nxt;
  logic r_bready, w_bready_nxt;
  logic r_arvalid, w_arvalid_nxt;
  logic r_rready, w_rready_nxt;
  logic r_rsp_valid, w_rsp_valid_nxt;
  logic r_rsp_write, w_rsp_write_nxt;
  logic r_aw_done, w_aw_done_nxt;
  logic r_w_done, w_w_done_nxt;
  logic r_busy, w_busy_nxt;
  logic [AXI_ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
  logic [AXI_DATA_WIDTH-1:0]   r_wdata, w_wdata_nxt;
  logic [AXI_DATA_WIDTH/8-1:0] r_wstrb, w_wstrb_nxt;
  logic [AXI_DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic [1:0]                  r_rsp_resp, w_rsp_resp_nxt;
  logic [7:0]                  r_err_cnt, w_err_cnt_nxt;
  logic                        w_capture;
  logic [1:0]                  w_cap_resp;

  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = r_cmd_ready;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_write_nxt = r_rsp_write;
    w_aw_done_nxt   = r_aw_done;
    w_w_done_nxt    = r_w_done;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_resp_nxt  = r_rsp_resp;
    w_capture       = 1'b0;
    w_cap_resp      = OKAY;

    case (r_state)
      IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_cmd_ready_nxt = 1'b0;
          w_addr_nxt      = cmd_addr;
          w_wdata_nxt     = cmd_wdata;
          w_wstrb_nxt     = cmd_wstrb;
          w_rsp_write_nxt = cmd_write;
          if (cmd_write) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_aw_done_nxt = 1'b0;
            w_w_done_nxt  = 1'b0;
            w_state_nxt   = WR_AW_W;
          end else begin
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = RD_AR;
          end
        end
      end
      WR_AW_W: begin
        // AW and W complete independently; B is only accepted once both have.
        if (r_awvalid && m_axi_awready) begin
          w_awvalid_nxt = 1'b0;
          w_aw_done_nxt = 1'b1;
        end
        if (r_wvalid && m_axi_wready) begin
          w_wvalid_nxt = 1'b0;
          w_w_done_nxt = 1'b1;
        end
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = WR_B;
        end
      end
      WR_B: begin
        if (m_axi_bvalid) begin
          w_bready_nxt    = 1'b0;
          w_rsp_rdata_nxt = '0;
          w_rsp_resp_nxt  = m_axi_bresp;
          w_rsp_valid_nxt = 1'b1;
          w_capture       = 1'b1;
          w_cap_resp      = m_axi_bresp;
          w_state_nxt     = RSP;
        end
      end
      RD_AR: begin
        if (m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = RD_R;
        end
      end
      RD_R: begin
        if (m_axi_rvalid) begin
          w_rready_nxt    = 1'b0;
          w_rsp_rdata_nxt = m_axi_rdata;
          w_rsp_resp_nxt  = m_axi_rresp;
          w_rsp_valid_nxt = 1'b1;
          w_capture       = 1'b1;
          w_cap_resp      = m_axi_rresp;
          w_state_nxt     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_cmd_ready_nxt = 1'b1;
      end
    endcase

    w_busy_nxt    = (w_state_nxt != IDLE);
    w_err_cnt_nxt = r_err_cnt;
    if (w_capture && (w_cap_resp != OKAY) && (r_err_cnt != 8'hFF))
      w_err_cnt_nxt = r_err_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_busy      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_write <= w_rsp_write_nxt;
      r_aw_done   <= w_aw_done_nxt;
      r_w_done    <= w_w_done_nxt;
      r_busy      <= w_busy_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_resp  <= w_rsp_resp_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_write     = r_rsp_write;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_bready  = r_bready;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = r_rready;
  assign busy          = r_busy;
  assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_crf_lite_master.sv
// Bench for crf_lite_master: behavioural AXI4-Lite register slave plus a reference register model.
module tb_crf_lite_master;
  import crf_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        busy;
  logic [7:0]  err_cnt;

  crf_lite_master #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .busy(busy), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave knobs, set by the stimulus between commands.
  int unsigned aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  s_resp = OKAY;
  // Monitor results.
  int unsigned viol = 0, aw_hi = 0, w_hi = 0;
  logic        upstart_seen = 1'b0;

  logic [31:0] mem [16];
  logic        have_aw, have_w, have_ar;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic        p_awv, p_wv, p_arv, p_bready, p_rready;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;
  int unsigned aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;

  // Register-file slave; acts on the falling edge so handshakes resolve at the next rising edge.
  initial begin : axi_slave
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = OKAY;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = OKAY;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = OKAY;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = OKAY;
        have_aw = 1'b0; have_w = 1'b0; have_ar = 1'b0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0; p_bready = 1'b0; p_rready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        continue;
      end
      hs_aw = p_awv && m_axi_awready;
      hs_w  = p_wv && m_axi_wready;
      hs_ar = p_arv && m_axi_arready;
      hs_b  = m_axi_bvalid && p_bready;
      hs_r  = m_axi_rvalid && p_rready;
      if (p_awv && !hs_aw && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) viol++;
      if (p_wv && !hs_w && (!m_axi_wvalid || m_axi_wdata != p_wdata || m_axi_wstrb != p_wstrb)) viol++;
      if (p_arv && !hs_ar && (!m_axi_arvalid || m_axi_araddr != p_araddr)) viol++;
      if ((hs_aw && m_axi_awvalid) || (hs_w && m_axi_wvalid) || (hs_ar && m_axi_arvalid)) viol++;
      if (p_bready && !hs_b && !m_axi_bready) viol++;
      if (p_rready && !hs_r && !m_axi_rready) viol++;
      if (m_axi_bready && (m_axi_awvalid || m_axi_wvalid)) viol++;
      if (busy == cmd_ready) viol++;
      if (m_axi_awprot != 3'b000 || m_axi_arprot != 3'b000) viol++;
      if (m_axi_awvalid) aw_hi++;
      if (m_axi_wvalid) w_hi++;

      if (hs_aw) begin have_aw = 1'b1; s_awaddr = p_awaddr; m_axi_awready = 1'b0; aw_cnt = 0; end
      if (hs_w) begin have_w = 1'b1; s_wdata = p_wdata; s_wstrb = p_wstrb; m_axi_wready = 1'b0; w_cnt = 0; end
      if (hs_ar) begin have_ar = 1'b1; s_araddr = p_araddr; m_axi_arready = 1'b0; ar_cnt = 0; end
      if (hs_b) m_axi_bvalid = 1'b0;
      if (hs_r) m_axi_rvalid = 1'b0;

      if (m_axi_awvalid && !m_axi_awready) begin
        if (aw_cnt >= aw_dly) m_axi_awready = 1'b1; else aw_cnt++;
      end
      if (m_axi_wvalid && !m_axi_wready) begin
        if (w_cnt >= w_dly) m_axi_wready = 1'b1; else w_cnt++;
      end
      if (m_axi_arvalid && !m_axi_arready) begin
        if (ar_cnt >= ar_dly) m_axi_arready = 1'b1; else ar_cnt++;
      end
      if (have_aw && have_w && !m_axi_bvalid) begin
        if (b_cnt >= b_dly) begin
          if (s_resp == OKAY) begin
            for (int b = 0; b < 4; b++)
              if (s_wstrb[b]) mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
            if (s_awaddr == UPSTR && s_wstrb[0] && s_wdata[0]) upstart_seen = 1'b1;
          end
          m_axi_bvalid = 1'b1; m_axi_bresp = s_resp;
          have_aw = 1'b0; have_w = 1'b0; b_cnt = 0;
        end else b_cnt++;
      end
      if (have_ar && !m_axi_rvalid) begin
        if (r_cnt >= r_dly) begin
          m_axi_rvalid = 1'b1; m_axi_rdata = mem[s_araddr[5:2]]; m_axi_rresp = s_resp;
          have_ar = 1'b0; r_cnt = 0;
        end else r_cnt++;
      end
      p_awv = m_axi_awvalid; p_awaddr = m_axi_awaddr;
      p_wv = m_axi_wvalid; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
      p_arv = m_axi_arvalid; p_araddr = m_axi_araddr;
      p_bready = m_axi_bready; p_rready = m_axi_rready;
    end
  end

  // Reference model: registers as a sparse map, error count as a clamped tally.
  logic [31:0] ref_mem [logic [31:0]];
  int unsigned ref_err = 0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = ref_read(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = v;
  endtask

  task automatic ref_resp(input logic [1:0] r);
    if (r != OKAY && ref_err < 255) ref_err++;
  endtask

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int unsigned hold,
                        output logic [31:0] rdata, output logic [1:0] resp,
                        output int unsigned lat, output int unsigned busy_drop);
    int unsigned t;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    rsp_ready = (hold == 0);
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    chk("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = (hold != 0);
    aw_hi = 0; w_hi = 0;
    lat = 0; busy_drop = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!busy) busy_drop++;
    end while (!rsp_valid && lat < 200);
    chk("rsp_timeout", rsp_valid, 1'b1);
    chk("rsp_write", rsp_write, wr);
    rdata = rsp_rdata; resp = rsp_resp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_rdata", rsp_rdata, rdata);
      chk("bp_resp", rsp_resp, resp);
      chk("bp_cmd_ready", cmd_ready, 1'b0);
      chk("bp_axi_valid", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
    end
    if (hold != 0) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1; cmd_valid = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk("cmd_ready_ret", {cmd_ready, rsp_valid}, 2'b10);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  logic [31:0]  rd, exp_rd, a, d;
  logic [1:0]   rs;
  logic [3:0]   st;
  logic         wr;
  int unsigned  lat, bdrop, t;

  initial begin : stim
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;
    #3;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 4'b0000);
    chk("rst_readys", {m_axi_bready, m_axi_rready}, 2'b00);
    chk("rst_err_cnt", err_cnt, 8'd0);
    chk("rst_data", m_axi_awaddr | m_axi_wdata | m_axi_araddr | rsp_rdata, 32'h0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Start register write, slave ready immediately.
    do_cmd(1'b1, UPSTR, 32'h0000_0001, 4'hF, 0, rd, rs, lat, bdrop);
    ref_write(UPSTR, 32'h0000_0001, 4'hF); ref_resp(OKAY);
    chk("wr_lat", lat, 3);
    chk("wr_aw_cycles", aw_hi, 1);
    chk("wr_w_cycles", w_hi, 1);
    chk("wr_resp", rs, OKAY);
    chk("wr_rdata", rd, 32'h0);
    chk("upstart", upstart_seen, 1'b1);

    // W accepted three cycles before AW.
    aw_dly = 3; w_dly = 0;
    d = $urandom;
    do_cmd(1'b1, UPENDR, d, 4'hF, 0, rd, rs, lat, bdrop);
    ref_write(UPENDR, d, 4'hF); ref_resp(OKAY);
    chk("skew_aw_cycles", aw_hi, 4);
    chk("skew_w_cycles", w_hi, 1);
    chk("skew_resp", rs, OKAY);
    aw_dly = 0;

    // Read back with a slow R beat.
    r_dly = 5;
    do_cmd(1'b0, UPSTR, 32'h0, 4'h0, 0, rd, rs, lat, bdrop);
    ref_resp(OKAY);
    chk("rb_rdata", rd, ref_read(UPSTR));
    chk("rb_resp", rs, OKAY);
    chk("rb_busy_drop", bdrop, 0);
    chk("rb_lat", lat, 8);
    r_dly = 0;

    // Random traffic with random slave timing and occasional error responses.
    for (int i = 0; i < 40; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      s_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : OKAY;
      wr = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 15)) << 2;
      d = $urandom;
      st = 4'($urandom_range(1, 15));
      exp_rd = wr ? 32'h0 : ref_read(a);
      do_cmd(wr, a, d, st, 0, rd, rs, lat, bdrop);
      chk("rnd_resp", rs, s_resp);
      chk("rnd_rdata", rd, exp_rd);
      if (wr && s_resp == OKAY) ref_write(a, d, st);
      ref_resp(s_resp);
      chk("rnd_err_cnt", err_cnt, ref_err);
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;

    // Error counter saturation.
    s_resp = SLVERR;
    for (int i = 0; i < 300; i++) begin
      do_cmd(1'b1, 32'($urandom_range(0, 15)) << 2, $urandom, 4'hF, 0, rd, rs, lat, bdrop);
      ref_resp(SLVERR);
      chk("sat_resp", rs, SLVERR);
      chk("sat_err_cnt", err_cnt, ref_err);
    end
    chk("sat_final", err_cnt, 8'd255);
    s_resp = OKAY;

    // Response backpressure while another command is requested.
    do_cmd(1'b0, UPENDR, 32'h0, 4'h0, 10, rd, rs, lat, bdrop);
    chk("bp_rdata_final", rd, ref_read(UPENDR));
    chk("bp_resp_final", rs, OKAY);

    // Reset while AR is pending.
    ar_dly = 6;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = UPENDR;
    @(negedge clk);
    chk("mid_accept", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!m_axi_arvalid && t < 20) begin @(negedge clk); t++; end
    chk("mid_arvalid_pre", m_axi_arvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_arvalid", m_axi_arvalid, 1'b0);
    chk("mid_cmd_ready", cmd_ready, 1'b1);
    chk("mid_err_cnt", err_cnt, 8'd0);
    chk("mid_busy_rsp", {busy, rsp_valid}, 2'b00);
    ref_mem.delete();
    ref_err = 0;
    ar_dly = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    do_cmd(1'b0, UPENDR, 32'h0, 4'h0, 0, rd, rs, lat, bdrop);
    chk("post_rst_rdata", rd, ref_read(UPENDR));
    chk("post_rst_resp", rs, OKAY);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_err_cnt", err_cnt, ref_err);

    chk("protocol_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
